// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: strobes one active-low row per dwell, reads active-low columns,
// debounces over whole scans and hands one key code per press to a valid/ack consumer.
module keypad_scanner #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [COLS-1:0] col,
  output logic [ROWS-1:0] row,
  output logic [3:0]      key_code,
  output logic            key_valid,
  input  logic            key_ack,
  output logic            key_down,
  output logic            overflow
);

  localparam int DW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

  logic [COLS-1:0] col_meta;
  logic [COLS-1:0] col_sync;
  logic [DW-1:0]   dwell;
  logic [1:0]      row_idx;
  logic            found;
  logic [3:0]      best;
  state_t          state;
  logic [3:0]      cnt;
  logic [3:0]      cand;

  logic            tc;
  logic            first_row;
  logic            last_row;
  logic            row_hit;
  logic [3:0]      row_code;
  logic            scan_done;
  logic            scan_found;
  logic [3:0]      scan_code;
  logic [ROWS-1:0] row_rot;
  logic [4:0]      cnt_inc;
  logic            debounced;
  logic            accept;
  logic            release_key;

  assign tc        = (dwell == DW'(SCAN_DIV - 1));
  assign first_row = (row_idx == 2'd0);
  assign last_row  = (row_idx == 2'(ROWS - 1));
  assign scan_done = tc && last_row;

  // Lowest pressed column of the row being sampled; scanning downwards leaves the lowest.
  always_comb begin
    row_hit  = 1'b0;
    row_code = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!col_sync[c]) begin
        row_hit  = 1'b1;
        row_code = 4'(int'(row_idx) * COLS + c);
      end
    end
  end

  // An earlier row's hit has a lower index, so it keeps priority over this row.
  assign scan_found = (!first_row && found) || row_hit;
  assign scan_code  = (!first_row && found) ? best : row_code;

  always_comb begin
    row_rot    = '1;
    row_rot[0] = row[ROWS-1];
    for (int i = 1; i < ROWS; i++) begin
      row_rot[i] = row[i-1];
    end
  end

  assign cnt_inc     = {1'b0, cnt} + 5'd1;
  assign debounced   = (cnt_inc >= 5'(DEBOUNCE));
  assign accept      = scan_done && scan_found &&
                       ((state == IDLE && DEBOUNCE == 1) ||
                        (state == PRESS_DB && scan_code == cand && debounced));
  assign release_key = scan_done && !scan_found &&
                       ((state == HELD && DEBOUNCE == 1) ||
                        (state == REL_DB && debounced));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_meta <= '1;
      col_sync <= '1;
      dwell    <= '0;
      row      <= ~ROWS'(1);
      row_idx  <= '0;
      found    <= 1'b0;
      best     <= '0;
    end else begin
      col_meta <= col;
      col_sync <= col_meta;
      if (tc) begin
        dwell   <= '0;
        row     <= row_rot;
        row_idx <= last_row ? 2'd0 : row_idx + 2'd1;
        found   <= scan_found;
        best    <= scan_code;
      end else begin
        dwell <= dwell + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      // A simultaneous accept beats the ack, and is not an overflow.
      if (accept) begin
        key_code  <= scan_code;
        key_valid <= 1'b1;
        key_down  <= 1'b1;
        if (key_valid && !key_ack) overflow <= 1'b1;
      end else if (key_ack) begin
        key_valid <= 1'b0;
      end
      if (release_key) key_down <= 1'b0;

      if (scan_done) begin
        case (state)
          IDLE: begin
            if (scan_found) begin
              cand  <= scan_code;
              cnt   <= 4'd1;
              state <= accept ? HELD : PRESS_DB;
            end
          end
          PRESS_DB: begin
            if (!scan_found) begin
              cnt   <= '0;
              state <= IDLE;
            end else if (scan_code != cand) begin
              cand <= scan_code;
              cnt  <= 4'd1;
            end else if (accept) begin
              cnt   <= 4'(DEBOUNCE);
              state <= HELD;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          HELD: begin
            if (!scan_found) begin
              cnt   <= release_key ? 4'd0 : 4'd1;
              state <= release_key ? IDLE : REL_DB;
            end
          end
          REL_DB: begin
            if (scan_found) begin
              state <= HELD;
            end else if (release_key) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model drives col from row, expected
// accept events are queued by the stimulus and checked by a monitor on key_down rising.
`timescale 1ns/1ps
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ack = 1'b0;
  logic        key_down;
  logic        overflow;
  logic [15:0] pressed = 16'h0;

  int checks = 0;
  int errors = 0;
  int cyc;

  typedef struct {
    int code;
    bit ov;
    int cycle;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(8), .DEBOUNCE(3)) dut (
    .clk(clk), .rst(rst), .col(col), .row(row), .key_code(key_code),
    .key_valid(key_valid), .key_ack(key_ack), .key_down(key_down), .overflow(overflow)
  );

  // Keypad matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  // Cycles since reset release: the first post-reset posedge makes this 1.
  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    key_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_row", row, 4'b1110);
    check("rst_key_code", key_code, 0);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_down", key_down, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b1;
  endtask

  task automatic expect_drained(input string name);
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  // Monitor: every accept raises key_down, since accepts only happen from released states.
  initial begin
    bit   kd_prev;
    exp_t e;
    kd_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && key_down && !kd_prev) begin
        $display("accept: cyc=%0d code=%0d valid=%0d overflow=%0d", cyc, key_code, key_valid, overflow);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_accept: got code %0d at cyc %0d, required no accept", key_code, cyc);
        end else begin
          e = sb.pop_front();
          check("accept_code", key_code, e.code);
          check("accept_valid", key_valid, 1);
          check("accept_overflow", overflow, e.ov);
          if (e.cycle >= 0) check("accept_cycle", cyc, e.cycle);
        end
      end
      kd_prev = key_down;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;

    // 1: idle scanning, row sequence and quiet outputs
    pressed = 16'h0;
    do_reset();
    check("row_c0", row, 4'b1110);
    wait_cyc(8);  check("row_c8", row, 4'b1101);
    wait_cyc(16); check("row_c16", row, 4'b1011);
    wait_cyc(24); check("row_c24", row, 4'b0111);
    wait_cyc(32); check("row_c32", row, 4'b1110);
    bad = 0;
    while (cyc < 320) begin
      if (key_valid || key_down || overflow) bad++;
      @(negedge clk);
    end
    check("idle_quiet", bad, 0);

    // 2: key 9 press, ack, hold, release
    pressed = 16'h0;
    do_reset();
    pressed = 16'h0200;
    sb.push_back('{code: 9, ov: 1'b0, cycle: 96});
    wait_cyc(100);
    check("k9_valid_before_ack", key_valid, 1);
    key_ack = 1'b1;
    wait_cyc(101);
    check("k9_valid_after_ack", key_valid, 0);
    key_ack = 1'b0;
    wait_cyc(128);
    check("k9_held_no_revalid", key_valid, 0);
    pressed = 16'h0;
    wait_cyc(223);
    check("k9_down_before_rel", key_down, 1);
    wait_cyc(224);
    check("k9_down_after_rel", key_down, 0);
    expect_drained("k9_events");

    // 3: key 9 bouncing on alternate scans never accepts
    pressed = 16'h0;
    do_reset();
    bad = 0;
    while (cyc < 384) begin
      pressed = ((cyc / 32) % 2 == 0) ? 16'h0200 : 16'h0000;
      if (key_valid || key_down) bad++;
      @(negedge clk);
    end
    check("bounce_quiet", bad, 0);
    pressed = 16'h0;
    expect_drained("bounce_events");

    // 4: keys 1 and 14 together, lowest wins
    do_reset();
    pressed = 16'h4002;
    sb.push_back('{code: 1, ov: 1'b0, cycle: 96});
    wait_cyc(110);
    expect_drained("multi_events");
    pressed = 16'h0;

    // 5a: second press without ack sets overflow
    do_reset();
    pressed = 16'h0200;
    sb.push_back('{code: 9, ov: 1'b0, cycle: 96});
    wait_cyc(128);
    pressed = 16'h0;
    wait_cyc(224);
    pressed = 16'h0010;
    sb.push_back('{code: 4, ov: 1'b1, cycle: 320});
    wait_cyc(330);
    check("ovf_sticky", overflow, 1);
    expect_drained("ovf_events");
    pressed = 16'h0;

    // 5b: ack on the accept cycle, accept wins without overflow
    do_reset();
    pressed = 16'h0200;
    sb.push_back('{code: 9, ov: 1'b0, cycle: 96});
    wait_cyc(128);
    pressed = 16'h0;
    wait_cyc(224);
    pressed = 16'h0010;
    wait_cyc(319);
    key_ack = 1'b1;
    sb.push_back('{code: 4, ov: 1'b0, cycle: 320});
    wait_cyc(320);
    key_ack = 1'b0;
    wait_cyc(321);
    check("ackwin_valid", key_valid, 1);
    check("ackwin_overflow", overflow, 0);
    check("ackwin_code", key_code, 4);
    expect_drained("ackwin_events");
    pressed = 16'h0;

    // 6: reset mid-debounce with key 9 held
    do_reset();
    pressed = 16'h0200;
    wait_cyc(50);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_row", row, 4'b1110);
    check("midrst_valid", key_valid, 0);
    check("midrst_down", key_down, 0);
    check("midrst_code", key_code, 0);
    @(negedge clk);
    rst = 1'b1;
    sb.push_back('{code: 9, ov: 1'b0, cycle: 96});
    wait_cyc(95);
    check("midrst_no_early_valid", key_valid, 0);
    wait_cyc(110);
    expect_drained("midrst_events");
    pressed = 16'h0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
